hive_mbox_ring: RTL and testbench
=================================

// Module: hive_mbox_ring
//
// PURPOSE
// - Inter-thread mailbox: 8 BRAM-backed FIFOs, one per thread, written by any thread, read only by the owner.
// - Writer side addresses the destination thread's queue; reader side drains the thread's own queue in arrival order.
// - Sits beside the per-thread stacks in the core pipeline; pushes/pops come from the op decode stages, errors go to the thread error logic.
//
// PARAMETERS
// - THD_W   3   thread ID width; 2**THD_W queues
// - DATA_W  32  entry width
// - PTR_W   5   per-queue address width; depth = 2**PTR_W entries per queue
//
// PORTS
// - clk_i      in   1             clock
// - rst_n_i    in   1             reset; one clock, reset is asynchronous and active-low
// - cls_i      in   1             clear queue cls_id_i
// - cls_id_i   in   THD_W         queue to clear
// - wr_i       in   1             write request
// - wr_id_i    in   THD_W         destination queue
// - wr_data_i  in   DATA_W        write data
// - rd_i       in   1             read (pop) request
// - rd_id_i    in   THD_W         queue to read (the reading thread's own ID)
// - rd_data_o  out  DATA_W        read data, valid with rd_vld_o
// - rd_vld_o   out  1             read data valid pulse
// - wr_er_o    out  1             write to full queue, one-cycle pulse
// - rd_er_o    out  1             read of empty queue, one-cycle pulse
// - emp_o      out  2**THD_W      per-queue empty flags
// - full_o     out  2**THD_W      per-queue full flags
//
// BEHAVIOUR
// - State per queue q: wptr[q], rptr[q] (PTR_W bits, wrap mod 2**PTR_W), cnt[q] (PTR_W+1 bits, 0..2**PTR_W).
// - Memory: simple dual-port, 2**(THD_W+PTR_W) x DATA_W; wr addr {wr_id_i,wptr}, rd addr {rd_id_i,rptr}; registered read output.
// - Reset: all wptr/rptr/cnt = 0; rd_data_o = 0, rd_vld_o = 0, wr_er_o = 0, rd_er_o = 0, emp_o = all 1, full_o = all 0. Memory contents undefined.
// - Per cycle, evaluated on cnt at start of cycle (no write->read bypass within a cycle):
//   - cls_i: cnt/wptr/rptr of cls_id_i <= 0. Write or read to same queue that cycle is ignored, no error, no rd_vld_o.
//   - wr_i: if cnt = 2**PTR_W -> dropped, wr_er_o = 1 next cycle; else mem write, wptr++, cnt++.
//   - rd_i: if cnt = 0 -> rd_er_o = 1 next cycle, pointers unchanged, no rd_vld_o; else rptr++, cnt--, read issued.
//   - wr_i and rd_i same queue, cnt neither 0 nor full: both succeed, cnt unchanged.
//   - wr_i and rd_i same queue, cnt = 0: read errors, write succeeds (cnt -> 1).
//   - wr_i and rd_i same queue, cnt full: both succeed (read frees the slot the write fills; cnt unchanged).
//   - Different queues: fully independent.
// - Read latency: rd_i at cycle N -> rd_vld_o and rd_data_o at cycle N+2; rd_vld_o one-cycle pulse; rd_data_o holds last value otherwise.
// - Write at cycle N, read same queue at N+1: read returns that data at N+3 (memory written at end of N).
// - emp_o/full_o registered from cnt: reflect cnt after each cycle's update (1-cycle after the causing request).
// - Error pulses are 1 cycle after the offending request; back-to-back offences give back-to-back pulses.
// - Async reset mid-operation: all state and outputs to reset values immediately; in-flight reads are discarded (no rd_vld_o after reset release).
//
// TESTING
// - Reset, then wr q3 = 0xA, 0xB, 0xC on cycles 0-2, rd q3 x3 from cycle 3 -> rd_vld_o at 5,6,7 with 0xA,0xB,0xC; emp_o[3] = 1 after cycle 5.
// - Read empty q0 -> rd_er_o = 1 one cycle later, no rd_vld_o, pointers unchanged; following wr/rd of q0 returns correct data.
// - Fill q7 with 32 writes -> full_o[7] = 1; 33rd write -> wr_er_o pulse, data dropped; 32 reads return first 32 values in order.
// - Fill q5 full, same-cycle wr 0x55 + rd -> no errors, full_o[5] stays 1; drain returns entries 1..31 then 0x55 (pointer wrap).
// - Writes to q1 interleaved with reads of q2 every cycle for 100 cycles -> independent order, no cross-queue data, no errors.
// - Load q4 with 4 entries, cls_i q4 with same-cycle wr q4 -> emp_o[4] = 1, next rd q4 errors; assert rst_n_i low during pending read -> no rd_vld_o, all flags reset.

Source files
------------

// File: rtl/hive_mbox_ring.sv
// Inter-thread mailbox: one FIFO per thread in a shared simple dual-port memory.
// Any thread may push into any queue; only the owning thread pops its own queue.
module hive_mbox_ring #(
  parameter int THD_W  = 3,
  parameter int DATA_W = 32,
  parameter int PTR_W  = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cls_i,
  input  logic [THD_W-1:0]        cls_id_i,
  input  logic                    wr_i,
  input  logic [THD_W-1:0]        wr_id_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    rd_i,
  input  logic [THD_W-1:0]        rd_id_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    rd_vld_o,
  output logic                    wr_er_o,
  output logic                    rd_er_o,
  output logic [(2**THD_W)-1:0]   emp_o,
  output logic [(2**THD_W)-1:0]   full_o
);

  localparam int NQ    = 2**THD_W;
  localparam int MEM_D = 2**(THD_W+PTR_W);
  localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0] CNT_FULL = {1'b1, {PTR_W{1'b0}}};

  logic [DATA_W-1:0] mem_r [MEM_D];
  logic [PTR_W-1:0]  wptr_r [NQ];
  logic [PTR_W-1:0]  rptr_r [NQ];
  logic [PTR_W:0]    cnt_r  [NQ];
  logic [PTR_W-1:0]  wptr_nxt_s [NQ];
  logic [PTR_W-1:0]  rptr_nxt_s [NQ];
  logic [PTR_W:0]    cnt_nxt_s  [NQ];
  logic [DATA_W-1:0] rd_q_r;
  logic              rd_p1_r;
  logic              wr_cls_s, rd_cls_s, wr_ok_s, rd_ok_s, wr_er_s, rd_er_s;

  // Request qualification against the counts held at the start of the cycle
  always_comb begin
    wr_cls_s = cls_i && (cls_id_i == wr_id_i);
    rd_cls_s = cls_i && (cls_id_i == rd_id_i);
    rd_ok_s  = rd_i && !rd_cls_s && (cnt_r[rd_id_i] != CNT_ZERO);
    // A full queue still accepts a write when the same cycle pops it
    wr_ok_s  = wr_i && !wr_cls_s &&
               ((cnt_r[wr_id_i] != CNT_FULL) || (rd_ok_s && (rd_id_i == wr_id_i)));
    wr_er_s  = wr_i && !wr_cls_s && !wr_ok_s;
    rd_er_s  = rd_i && !rd_cls_s && !rd_ok_s;
  end

  // Next pointer/count per queue; clear wins over any same-queue access
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      wptr_nxt_s[q] = wptr_r[q];
      rptr_nxt_s[q] = rptr_r[q];
      cnt_nxt_s[q]  = cnt_r[q];
      if (cls_i && (cls_id_i == THD_W'(q))) begin
        wptr_nxt_s[q] = {PTR_W{1'b0}};
        rptr_nxt_s[q] = {PTR_W{1'b0}};
        cnt_nxt_s[q]  = CNT_ZERO;
      end else begin
        wptr_nxt_s[q] = wptr_r[q] + {{(PTR_W-1){1'b0}}, (wr_ok_s && (wr_id_i == THD_W'(q)))};
        rptr_nxt_s[q] = rptr_r[q] + {{(PTR_W-1){1'b0}}, (rd_ok_s && (rd_id_i == THD_W'(q)))};
        cnt_nxt_s[q]  = cnt_r[q]
                      + {{PTR_W{1'b0}}, (wr_ok_s && (wr_id_i == THD_W'(q)))}
                      - {{PTR_W{1'b0}}, (rd_ok_s && (rd_id_i == THD_W'(q)))};
      end
    end
  end

  // Queue state, status flags, error pulses and first read-pipeline stage
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int q = 0; q < NQ; q++) begin
        wptr_r[q] <= {PTR_W{1'b0}};
        rptr_r[q] <= {PTR_W{1'b0}};
        cnt_r[q]  <= CNT_ZERO;
      end
      emp_o   <= {NQ{1'b1}};
      full_o  <= {NQ{1'b0}};
      wr_er_o <= 1'b0;
      rd_er_o <= 1'b0;
      rd_p1_r <= 1'b0;
    end else begin
      for (int q = 0; q < NQ; q++) begin
        wptr_r[q] <= wptr_nxt_s[q];
        rptr_r[q] <= rptr_nxt_s[q];
        cnt_r[q]  <= cnt_nxt_s[q];
        emp_o[q]  <= (cnt_nxt_s[q] == CNT_ZERO);
        full_o[q] <= (cnt_nxt_s[q] == CNT_FULL);
      end
      wr_er_o <= wr_er_s;
      rd_er_o <= rd_er_s;
      rd_p1_r <= rd_ok_s;
    end
  end

  // Block-RAM style storage; read-first so a full-queue wr+rd returns the old entry
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      mem_r[{wr_id_i, wptr_r[wr_id_i]}] <= wr_data_i;
    end
    if (rd_ok_s) begin
      rd_q_r <= mem_r[{rd_id_i, rptr_r[rd_id_i]}];
    end
  end

  // Output register stage; data holds its last value between pops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_vld_o  <= 1'b0;
      rd_data_o <= {DATA_W{1'b0}};
    end else begin
      rd_vld_o <= rd_p1_r;
      if (rd_p1_r) begin
        rd_data_o <= rd_q_r;
      end
    end
  end

endmodule

// File: tb/tb_hive_mbox_ring.sv
// Bench for hive_mbox_ring: queue-based reference model checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_hive_mbox_ring;

  logic        clk, rst_n, cls, wr, rd;
  logic [2:0]  cls_id, wr_id, rd_id;
  logic [31:0] wr_data, rd_data;
  logic        rd_vld, wr_er, rd_er;
  logic [7:0]  emp, full;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq [8][$];
  logic        p1_vld;
  logic [31:0] p1_data;
  logic        exp_vld, exp_wer, exp_rer;
  logic [31:0] exp_data;
  logic [7:0]  exp_emp, exp_full;

  hive_mbox_ring #(.THD_W(3), .DATA_W(32), .PTR_W(5)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .cls_i(cls), .cls_id_i(cls_id),
    .wr_i(wr), .wr_id_i(wr_id), .wr_data_i(wr_data),
    .rd_i(rd), .rd_id_i(rd_id), .rd_data_o(rd_data), .rd_vld_o(rd_vld),
    .wr_er_o(wr_er), .rd_er_o(rd_er), .emp_o(emp), .full_o(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int q = 0; q < 8; q++) mq[q].delete();
    p1_vld   = 1'b0;
    p1_data  = 32'h0;
    exp_vld  = 1'b0;
    exp_data = 32'h0;
    exp_wer  = 1'b0;
    exp_rer  = 1'b0;
    exp_emp  = 8'hFF;
    exp_full = 8'h00;
  endtask

  // one clock edge of the mailbox, expressed as queue operations
  task automatic model_edge();
    int s_rd, s_wr;
    bit rd_ok;
    logic [31:0] nd;
    exp_vld = p1_vld;
    if (p1_vld) exp_data = p1_data;
    exp_wer = 1'b0;
    exp_rer = 1'b0;
    rd_ok   = 1'b0;
    nd      = 32'h0;
    s_rd = mq[rd_id].size();
    s_wr = mq[wr_id].size();
    if (cls) mq[cls_id].delete();
    if (rd && !(cls && cls_id == rd_id)) begin
      if (s_rd == 0) exp_rer = 1'b1;
      else begin
        nd    = mq[rd_id].pop_front();
        rd_ok = 1'b1;
      end
    end
    if (wr && !(cls && cls_id == wr_id)) begin
      if (s_wr == 32 && !(rd_ok && rd_id == wr_id)) exp_wer = 1'b1;
      else mq[wr_id].push_back(wr_data);
    end
    p1_vld  = rd_ok;
    p1_data = nd;
    for (int q = 0; q < 8; q++) begin
      exp_emp[q]  = (mq[q].size() == 0);
      exp_full[q] = (mq[q].size() == 32);
    end
  endtask

  task automatic compare();
    chk("rd_vld", 32'(rd_vld), 32'(exp_vld));
    chk("rd_data", rd_data, exp_data);
    chk("wr_er", 32'(wr_er), 32'(exp_wer));
    chk("rd_er", 32'(rd_er), 32'(exp_rer));
    chk("emp", 32'(emp), 32'(exp_emp));
    chk("full", 32'(full), 32'(exp_full));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic step(input bit w, input logic [2:0] wi, input logic [31:0] d,
                      input bit r, input logic [2:0] ri);
    cls = 1'b0; cls_id = 3'd0;
    wr = w; wr_id = wi; wr_data = d;
    rd = r; rd_id = ri;
    cycle();
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 32'h0, 1'b0, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cls = 1'b0; cls_id = 3'd0; wr = 1'b0; wr_id = 3'd0; wr_data = 32'h0;
    rd = 1'b0; rd_id = 3'd0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    chk("reset_emp", 32'(emp), 32'h0000_00FF);
    chk("reset_full", 32'(full), 32'h0000_0000);

    // three writes then three pops of q3
    step(1'b1, 3'd3, 32'hA, 1'b0, 3'd0);
    step(1'b1, 3'd3, 32'hB, 1'b0, 3'd0);
    step(1'b1, 3'd3, 32'hC, 1'b0, 3'd0);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd3);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd3);
    chk("q3_first", rd_data, 32'hA);
    chk("q3_first_vld", 32'(rd_vld), 32'd1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd3);
    chk("q3_second", rd_data, 32'hB);
    idle();
    chk("q3_third", rd_data, 32'hC);
    chk("q3_empty", 32'(emp[3]), 32'd1);
    idle();

    // empty read of q0, then a normal round trip
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
    chk("q0_rd_er", 32'(rd_er), 32'd1);
    idle();
    step(1'b1, 3'd0, 32'h1234, 1'b0, 3'd0);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd0);
    idle();
    chk("q0_data", rd_data, 32'h1234);

    // fill q7, overflow, drain
    for (int i = 0; i < 32; i++) step(1'b1, 3'd7, 32'h700 + 32'(i), 1'b0, 3'd0);
    chk("q7_full", 32'(full[7]), 32'd1);
    step(1'b1, 3'd7, 32'hDEAD, 1'b0, 3'd0);
    chk("q7_wr_er", 32'(wr_er), 32'd1);
    for (int i = 0; i < 32; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 3'd7);
    idle();
    chk("q7_last", rd_data, 32'h71F);
    idle();
    chk("q7_empty", 32'(emp[7]), 32'd1);

    // full q5 with simultaneous push and pop, pointer wrap
    for (int i = 0; i < 32; i++) step(1'b1, 3'd5, 32'h500 + 32'(i), 1'b0, 3'd0);
    step(1'b1, 3'd5, 32'h55, 1'b1, 3'd5);
    chk("q5_no_wr_er", 32'(wr_er), 32'd0);
    chk("q5_no_rd_er", 32'(rd_er), 32'd0);
    chk("q5_still_full", 32'(full[5]), 32'd1);
    idle();
    chk("q5_pop0", rd_data, 32'h500);
    for (int i = 0; i < 32; i++) step(1'b0, 3'd0, 32'h0, 1'b1, 3'd5);
    idle();
    chk("q5_wrapped", rd_data, 32'h55);
    idle();

    // interleaved traffic on q1 and q2
    step(1'b1, 3'd2, 32'h2F00, 1'b0, 3'd0);
    step(1'b1, 3'd2, 32'h2F01, 1'b0, 3'd0);
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) step(1'b1, 3'd1, 32'h1000 + 32'(i), 1'b1, 3'd2);
      else            step(1'b1, 3'd2, 32'h2000 + 32'(i), 1'b1, 3'd1);
    end
    idle();
    idle();
    chk("q1q2_last", rd_data, 32'h1062);

    // clear q4 with same-cycle write, then read errors
    for (int i = 0; i < 4; i++) step(1'b1, 3'd4, 32'h400 + 32'(i), 1'b0, 3'd0);
    cls = 1'b1; cls_id = 3'd4; wr = 1'b1; wr_id = 3'd4; wr_data = 32'h44;
    rd = 1'b0; rd_id = 3'd0;
    cycle();
    chk("q4_cleared", 32'(emp[4]), 32'd1);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd4);
    chk("q4_rd_er", 32'(rd_er), 32'd1);

    // asynchronous reset while a pop is in flight
    step(1'b1, 3'd6, 32'h66, 1'b0, 3'd0);
    step(1'b0, 3'd0, 32'h0, 1'b1, 3'd6);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare();
    chk("arst_emp", 32'(emp), 32'h0000_00FF);
    chk("arst_full", 32'(full), 32'h0000_0000);
    idle();
    idle();
    rst_n = 1'b1;
    idle();
    idle();
    idle();
    chk("arst_no_vld", 32'(rd_vld), 32'd0);
    chk("arst_data", rd_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
